// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD sequencer.
package lcd_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_SETUP,
        INIT_PULSE,
        INIT_GAP,
        CFG_ISSUE,
        CFG_WAIT,
        CLR_DELAY,
        L1_ISSUE,
        L1_WAIT,
        CHAR_ISSUE,
        CHAR_WAIT,
        L2_ISSUE,
        L2_WAIT,
        IDLE
    } lcd_state_e;

    // LCD instruction bytes
    localparam logic [7:0] FUNC_SET   = 8'h28;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] LINE1      = 8'h80;
    localparam logic [7:0] LINE2      = 8'hC0;

    // Power-on nibbles: three wake-ups, then switch to 4-bit mode
    localparam logic [3:0] NIB_WAKE = 4'h3;
    localparam logic [3:0] NIB_4BIT = 4'h2;

    // instr_db field positions
    localparam int DB_RS = 9;
    localparam int DB_RW = 8;

    localparam int         TMR_W       = 20;
    localparam logic [11:0] CLK_CNT_MAX = 12'hFFF;

    function automatic logic [7:0] cfg_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return ENTRY_MODE;
            2'd2:    return DISP_ON;
            default: return CLEAR;
        endcase
    endfunction

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? NIB_4BIT : NIB_WAKE;
    endfunction

    function automatic logic [9:0] mk_db(input logic rs, input logic [7:0] b);
        logic [9:0] db;
        db        = '0;
        db[DB_RS] = rs;
        db[DB_RW] = 1'b0;
        db[7:0]   = b;
        return db;
    endfunction

    function automatic logic is_wait(input lcd_state_e s);
        return (s == CFG_WAIT) || (s == L1_WAIT) || (s == CHAR_WAIT) || (s == L2_WAIT);
    endfunction

    function automatic logic is_issue(input lcd_state_e s);
        return (s == CFG_ISSUE) || (s == L1_ISSUE) || (s == CHAR_ISSUE) || (s == L2_ISSUE);
    endfunction

    function automatic logic is_init(input lcd_state_e s);
        return (s == INIT_WAIT) || (s == INIT_SETUP) || (s == INIT_PULSE) || (s == INIT_GAP);
    endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter shared by every timed wait; expired while it reads 0.
module lcd_wait_timer
    import lcd_pkg::*;
#(
    parameter logic [TMR_W-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] value_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (value_q != '0) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign expired_o = (value_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// Character-LCD controller: power-on nibble init, config commands, 2x16 screen write.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERON = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_INIT3   = 2000,
    parameter int unsigned T_EPULSE  = 12,
    parameter int unsigned T_CLEAR   = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refresh_req,
    output logic [4:0]  char_addr,
    input  logic [7:0]  char_data,
    output logic        instr_next,
    output logic [9:0]  instr_db,
    input  logic        instr_done,
    output logic [11:0] clk_cnt,
    output logic        init_active,
    output logic        init_e,
    output logic [3:0]  init_d,
    output logic        ready
);

    // A state lasting N cycles loads N-1 on entry (timer reads N-1..0).
    localparam logic [TMR_W-1:0] L_POWERON = TMR_W'(T_POWERON);
    localparam logic [TMR_W-1:0] L_EPULSE  = TMR_W'(T_EPULSE - 1);
    localparam logic [TMR_W-1:0] L_CLEAR   = TMR_W'(T_CLEAR - 1);
    localparam logic [TMR_W-1:0] G_INIT1   = TMR_W'(T_INIT1);
    localparam logic [TMR_W-1:0] G_INIT2   = TMR_W'(T_INIT2);
    localparam logic [TMR_W-1:0] G_INIT3   = TMR_W'(T_INIT3);

    lcd_state_e       state_q, state_d;
    logic [1:0]       nib_idx_q, nib_idx_d;
    logic [1:0]       cfg_idx_q, cfg_idx_d;
    logic [4:0]       char_addr_q, char_addr_d;
    logic             pending_q, pending_d;
    logic [3:0]       init_d_q, init_d_d;
    logic [9:0]       instr_db_q, instr_db_d;
    logic             init_e_q, init_active_q, instr_next_q, ready_q;
    logic [11:0]      clk_cnt_q;
    logic             tmr_load, tmr_expired;
    logic [TMR_W-1:0] tmr_val, gap_cur;

    lcd_wait_timer #(.RESET_VAL(L_POWERON)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // Gap that follows the nibble currently on init_d.
    always_comb begin
        gap_cur = G_INIT3;
        case (nib_idx_q)
            2'd0:    gap_cur = G_INIT1;
            2'd1:    gap_cur = G_INIT2;
            default: gap_cur = G_INIT3;
        endcase
    end

    // Next-state, timer loads and held-value updates.
    always_comb begin
        state_d     = state_q;
        nib_idx_d   = nib_idx_q;
        cfg_idx_d   = cfg_idx_q;
        char_addr_d = char_addr_q;
        pending_d   = pending_q | (refresh_req & (state_q != IDLE));
        init_d_d    = init_d_q;
        instr_db_d  = instr_db_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            INIT_WAIT: begin
                if (tmr_expired) begin
                    state_d   = INIT_SETUP;
                    nib_idx_d = 2'd0;
                end
            end
            INIT_SETUP: begin
                state_d  = INIT_PULSE;
                tmr_load = 1'b1;
                tmr_val  = L_EPULSE;
            end
            INIT_PULSE: begin
                // Inter-nibble gaps include the next nibble's setup cycle;
                // the final gap is spent entirely in INIT_GAP.
                if (tmr_expired) begin
                    if (nib_idx_q == 2'd3) begin
                        state_d  = INIT_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = gap_cur - 1'b1;
                    end else if (gap_cur > TMR_W'(1)) begin
                        state_d  = INIT_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = gap_cur - TMR_W'(2);
                    end else begin
                        state_d   = INIT_SETUP;
                        nib_idx_d = nib_idx_q + 2'd1;
                    end
                end
            end
            INIT_GAP: begin
                if (tmr_expired) begin
                    if (nib_idx_q == 2'd3) begin
                        state_d   = CFG_ISSUE;
                        cfg_idx_d = 2'd0;
                    end else begin
                        state_d   = INIT_SETUP;
                        nib_idx_d = nib_idx_q + 2'd1;
                    end
                end
            end
            CFG_ISSUE: state_d = CFG_WAIT;
            CFG_WAIT: begin
                if (instr_done) begin
                    if (cfg_idx_q == 2'd3) begin
                        state_d  = CLR_DELAY;
                        tmr_load = 1'b1;
                        tmr_val  = L_CLEAR;
                    end else begin
                        state_d   = CFG_ISSUE;
                        cfg_idx_d = cfg_idx_q + 2'd1;
                    end
                end
            end
            CLR_DELAY: if (tmr_expired) state_d = L1_ISSUE;
            L1_ISSUE:  state_d = L1_WAIT;
            L1_WAIT: begin
                if (instr_done) begin
                    state_d     = CHAR_ISSUE;
                    char_addr_d = 5'd0;
                end
            end
            CHAR_ISSUE: state_d = CHAR_WAIT;
            CHAR_WAIT: begin
                if (instr_done) begin
                    if (char_addr_q == 5'd15) begin
                        state_d = L2_ISSUE;
                    end else if (char_addr_q == 5'd31) begin
                        // A request seen during the write (or on this very
                        // cycle) turns into one immediate rewrite.
                        if (pending_q || refresh_req) begin
                            state_d   = L1_ISSUE;
                            pending_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d     = CHAR_ISSUE;
                        char_addr_d = char_addr_q + 5'd1;
                    end
                end
            end
            L2_ISSUE: state_d = L2_WAIT;
            L2_WAIT: begin
                if (instr_done) begin
                    state_d     = CHAR_ISSUE;
                    char_addr_d = 5'd16;
                end
            end
            IDLE:    if (refresh_req) state_d = L1_ISSUE;
            default: state_d = INIT_WAIT;
        endcase

        if (state_d == INIT_SETUP) init_d_d = init_nibble(nib_idx_d);

        // Character byte is captured in CHAR_ISSUE and held through CHAR_WAIT.
        if (state_q == CHAR_ISSUE) instr_db_d = mk_db(1'b1, char_data);
        case (state_d)
            CFG_ISSUE: instr_db_d = mk_db(1'b0, cfg_cmd(cfg_idx_d));
            L1_ISSUE:  instr_db_d = mk_db(1'b0, LINE1);
            L2_ISSUE:  instr_db_d = mk_db(1'b0, LINE2);
            default:   ;
        endcase
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT_WAIT;
            nib_idx_q     <= 2'd0;
            cfg_idx_q     <= 2'd0;
            char_addr_q   <= 5'd0;
            pending_q     <= 1'b0;
            init_d_q      <= 4'd0;
            instr_db_q    <= 10'd0;
            init_e_q      <= 1'b0;
            init_active_q <= 1'b1;
            instr_next_q  <= 1'b0;
            ready_q       <= 1'b0;
            clk_cnt_q     <= 12'd0;
        end else begin
            state_q       <= state_d;
            nib_idx_q     <= nib_idx_d;
            cfg_idx_q     <= cfg_idx_d;
            char_addr_q   <= char_addr_d;
            pending_q     <= pending_d;
            init_d_q      <= init_d_d;
            instr_db_q    <= instr_db_d;
            init_e_q      <= (state_d == INIT_PULSE);
            init_active_q <= is_init(state_d);
            instr_next_q  <= is_issue(state_d);
            ready_q       <= (state_d == IDLE);
            if (is_wait(state_d))
                clk_cnt_q <= (clk_cnt_q == CLK_CNT_MAX) ? clk_cnt_q : clk_cnt_q + 12'd1;
            else
                clk_cnt_q <= 12'd0;
        end
    end

    assign char_addr   = char_addr_q;
    assign instr_next  = instr_next_q;
    assign instr_db    = (state_q == CHAR_ISSUE) ? mk_db(1'b1, char_data) : instr_db_q;
    assign clk_cnt     = clk_cnt_q;
    assign init_active = init_active_q;
    assign init_e      = init_e_q;
    assign init_d      = init_d_q;
    assign ready       = ready_q;

endmodule
